mor1kx_wb32_arbiter: RTL
========================

Name: mor1kx_wb32_arbiter

Overview:
- Shares one 32-bit Wishbone B3 master port between the instruction-side bridge (iwbm_*) and the data-side bridge (dwbm_*).
- Used in the MAROCCHINO stand-alone top when the SoC exposes a single bus port.
- Grants per bus cycle (whole CYC period, including bursts) under a selectable policy.
- Routes slave responses only to the current owner.

Parameters:
- ARB_POLICY, "ROUND_ROBIN", "ROUND_ROBIN" or "DBUS_PRIORITY"; applies when both requesters raise CYC in the same arbitration cycle.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; valid range 1..65535; used only when the optional feature is compiled in.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- iwbm_adr_i/dwbm_adr_i  in  32  requester address.
- iwbm_stb_i/dwbm_stb_i  in  1  requester strobe.
- iwbm_cyc_i/dwbm_cyc_i  in  1  requester cycle (request).
- iwbm_sel_i/dwbm_sel_i  in  4  byte selects.
- iwbm_we_i/dwbm_we_i  in  1  write enable.
- iwbm_cti_i/dwbm_cti_i  in  3  cycle type.
- iwbm_bte_i/dwbm_bte_i  in  2  burst type.
- iwbm_dat_i/dwbm_dat_i  in  32  write data.
- iwbm_ack_o/iwbm_err_o/iwbm_rty_o, dwbm_ack_o/dwbm_err_o/dwbm_rty_o  out  1 each  responses to requester.
- iwbm_dat_o/dwbm_dat_o  out  32  read data to requester.
- wbm_adr_o, wbm_stb_o, wbm_cyc_o, wbm_sel_o, wbm_we_o, wbm_cti_o, wbm_bte_o, wbm_dat_o  out  32/1/1/4/1/3/2/32  shared master port.
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each  shared slave responses.
- wbm_dat_i  in  32  shared read data.
- grant_o  out  2  {dbus, ibus} one-hot owner, 00 when idle.

Behaviour:
- FSM states IDLE, OWN_I, OWN_D; state register and last-owner bit are registered.
- Reset (synchronous, rst=1): state=IDLE, last_owner=DBUS (so ibus wins the first tie), grant_o=00, all wbm_* outputs 0, all *_ack/err/rty_o 0.
- Read-data outputs i/dwbm_dat_o carry wbm_dat_i unconditionally; they are qualified only by ack.
- IDLE:
  - Only one cyc_i high: go to its OWN state.
  - Both high, ROUND_ROBIN: grant the requester that is not last_owner.
  - Both high, DBUS_PRIORITY: grant dbus.
  - Grant latency is 1 cycle: cyc_i seen at edge n, wbm_cyc_o=1 from cycle n+1.
- OWN_x:
  - wbm_* outputs combinationally mirror requester x.
  - wbm_ack/err/rty_i route to x only; the other requester sees 0.
  - The non-owner waits with no bus activity; its cyc_i may stay high indefinitely.
- Release: when the owner's cyc_i is low in OWN_x, the shared wbm_cyc_o and wbm_stb_o drop in that same cycle (they mirror). Next state:
  - the other requester's OWN state if its cyc_i is high (fast handover, no idle cycle);
  - otherwise IDLE.
  - last_owner is updated to x.
- Bursts (cti 001/010) remain atomic: ownership never changes while the owner holds cyc_i.
- Simultaneous release of the owner and a new request from the same requester: the other requester wins if it is waiting (ROUND_ROBIN). Under DBUS_PRIORITY, dbus wins.
- A requester dropping cyc_i before being granted: no bus cycle is issued for it.
- rst mid-transaction: outputs go to 0 at the next edge. The slave may see CYC abort; this is accepted.

Optional Feature:
- Macro MOR1KX_WB32_ARB_WATCHDOG_EN.
- With the macro defined:
  - A 16-bit counter clears on any grant change or any wbm_ack_i/err_i/rty_i.
  - It increments each cycle while in OWN_x with wbm_stb_o=1 and no response.
  - When it reaches TIMEOUT_CYCLES, x_err_o pulses for exactly 1 cycle and wbm_cyc_o/wbm_stb_o are forced to 0 in that cycle.
  - The FSM then goes to IDLE and the counter clears.
  - Output timeout_o (1 bit, sticky) sets; it is cleared only by rst.
- Without the macro: no counter, no timeout_o port; a missing response stalls forever.

Decomposition:
- Shared package/defines header (mor1kx-defines.v style) holds:
  - state encodings ARB_IDLE=2'd0, ARB_OWN_I=2'd1, ARB_OWN_D=2'd2;
  - Wishbone CTI codes (000 classic, 010 incrementing, 111 end-of-burst).
- One sub-module is natural: mor1kx_wb32_arb_watchdog (counter, compare, sticky flag), instantiated only under the macro.

Test Plan:
- Single ibus 8-beat burst (cti 010 x7, then 111) at adr 0x100 → wbm_cyc_o rises 1 cycle after iwbm_cyc_i; 8 acks reach iwbm_ack_o; dwbm_ack_o stays 0; grant_o=01 throughout.
- Tie case: both cyc_i rise together after reset, ROUND_ROBIN → ibus granted first; at ibus release dbus is granted with no idle cycle; grant_o goes 01→10.
- Same tie with ARB_POLICY="DBUS_PRIORITY" → dbus granted first, grant_o=10.
- dbus classic write to 0x8000_0004, sel=0011, dat=0xDEAD_BEEF, issued while an ibus burst is in progress → dbus waits; wbm_* shows its values only after ibus cyc drops; wbm_we_o=1.
- rst=1 asserted mid-burst → next cycle all wbm_* outputs=0, grant_o=00; the following request is arbitrated normally.
- Watchdog (macro defined, TIMEOUT_CYCLES=4): slave never acks → dwbm_err_o pulses in the 4th stalled cycle, wbm_cyc_o=0 in that cycle, timeout_o=1 and remains set.

Source files
------------

// File: rtl/mor1kx_wb32_arbiter_pkg.sv
// Shared encodings for the 32-bit Wishbone I/D bus arbiter: FSM states,
// Wishbone cycle-type codes and the bundled master request.
package mor1kx_wb32_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_e;

  typedef enum logic [2:0] {
    WB_CTI_CLASSIC = 3'b000,
    WB_CTI_CONST   = 3'b001,
    WB_CTI_INC     = 3'b010,
    WB_CTI_EOB     = 3'b111
  } wb_cti_e;

  typedef struct packed {
    logic [31:0] adr;
    logic        stb;
    logic        cyc;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/mor1kx_wb32_arb_watchdog.sv
// Stalled-cycle watchdog for the bus arbiter: counts owner cycles with STB
// up and no slave response, fires a one-cycle abort and keeps a sticky flag.
module mor1kx_wb32_arb_watchdog
  import mor1kx_wb32_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic stb_i,
  input  logic resp_i,
  input  logic clr_i,
  output logic fire_o,
  output logic timeout_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_inc;
  logic        to_q, to_d;
  logic        stall;

  assign stall   = active_i & stb_i & ~resp_i;
  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  // Fires in the stalled cycle that brings the count to the limit.
  assign fire_o  = stall & (cnt_inc >= 17'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q | fire_o;
    if (clr_i || resp_i || fire_o || !active_i) cnt_d = '0;
    else if (stall)                             cnt_d = cnt_inc[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;

endmodule

// File: rtl/mor1kx_wb32_arbiter.sv
// Shares one Wishbone B3 master port between the ibus and dbus bridges,
// granting whole CYC periods. Optional watchdog: MOR1KX_WB32_ARB_WATCHDOG_EN.
module mor1kx_wb32_arbiter
  import mor1kx_wb32_arbiter_pkg::*;
#(
  parameter string ARB_POLICY     = "ROUND_ROBIN",
  parameter int    TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iwbm_adr_i,
  input  logic        iwbm_stb_i,
  input  logic        iwbm_cyc_i,
  input  logic [3:0]  iwbm_sel_i,
  input  logic        iwbm_we_i,
  input  logic [2:0]  iwbm_cti_i,
  input  logic [1:0]  iwbm_bte_i,
  input  logic [31:0] iwbm_dat_i,
  output logic        iwbm_ack_o,
  output logic        iwbm_err_o,
  output logic        iwbm_rty_o,
  output logic [31:0] iwbm_dat_o,
  input  logic [31:0] dwbm_adr_i,
  input  logic        dwbm_stb_i,
  input  logic        dwbm_cyc_i,
  input  logic [3:0]  dwbm_sel_i,
  input  logic        dwbm_we_i,
  input  logic [2:0]  dwbm_cti_i,
  input  logic [1:0]  dwbm_bte_i,
  input  logic [31:0] dwbm_dat_i,
  output logic        dwbm_ack_o,
  output logic        dwbm_err_o,
  output logic        dwbm_rty_o,
  output logic [31:0] dwbm_dat_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [31:0] wbm_dat_i,
  output logic [1:0]  grant_o
`ifdef MOR1KX_WB32_ARB_WATCHDOG_EN
  ,output logic       timeout_o
`endif
);

  localparam bit DPRIO = (ARB_POLICY == "DBUS_PRIORITY");

  if (!DPRIO && ARB_POLICY != "ROUND_ROBIN") begin : g_bad_policy
    $error("ARB_POLICY must be ROUND_ROBIN or DBUS_PRIORITY");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  arb_state_e state_q, state_d;
  logic       last_d_q, last_d_d;   // 1: dbus was the most recent owner
  logic       own_i, own_d;
  logic       wd_fire;
  wb_req_t    ireq, dreq, sel_req;

  assign own_i = (state_q == ARB_OWN_I);
  assign own_d = (state_q == ARB_OWN_D);

  assign ireq = '{adr: iwbm_adr_i, stb: iwbm_stb_i, cyc: iwbm_cyc_i, sel: iwbm_sel_i,
                  we: iwbm_we_i, cti: iwbm_cti_i, bte: iwbm_bte_i, dat: iwbm_dat_i};
  assign dreq = '{adr: dwbm_adr_i, stb: dwbm_stb_i, cyc: dwbm_cyc_i, sel: dwbm_sel_i,
                  we: dwbm_we_i, cti: dwbm_cti_i, bte: dwbm_bte_i, dat: dwbm_dat_i};
  assign sel_req = own_i ? ireq : (own_d ? dreq : '0);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (iwbm_cyc_i && dwbm_cyc_i)
          state_d = (DPRIO || !last_d_q) ? ARB_OWN_D : ARB_OWN_I;
        else if (iwbm_cyc_i) state_d = ARB_OWN_I;
        else if (dwbm_cyc_i) state_d = ARB_OWN_D;
      end
      // Ownership holds for the whole CYC period, so bursts stay atomic.
      ARB_OWN_I: begin
        if (!iwbm_cyc_i || wd_fire) begin
          last_d_d = 1'b0;
          state_d  = (dwbm_cyc_i && !wd_fire) ? ARB_OWN_D : ARB_IDLE;
        end
      end
      ARB_OWN_D: begin
        if (!dwbm_cyc_i || wd_fire) begin
          last_d_d = 1'b1;
          state_d  = (iwbm_cyc_i && !wd_fire) ? ARB_OWN_I : ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

`ifdef MOR1KX_WB32_ARB_WATCHDOG_EN
  mor1kx_wb32_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .active_i  (own_i | own_d),
    .stb_i     (sel_req.cyc & sel_req.stb),
    .resp_i    (wbm_ack_i | wbm_err_i | wbm_rty_i),
    .clr_i     (state_d != state_q),
    .fire_o    (wd_fire),
    .timeout_o (timeout_o)
  );
`else
  assign wd_fire = 1'b0;
`endif

  assign wbm_adr_o = sel_req.adr;
  assign wbm_stb_o = sel_req.stb & ~wd_fire;
  assign wbm_cyc_o = sel_req.cyc & ~wd_fire;
  assign wbm_sel_o = sel_req.sel;
  assign wbm_we_o  = sel_req.we;
  assign wbm_cti_o = sel_req.cti;
  assign wbm_bte_o = sel_req.bte;
  assign wbm_dat_o = sel_req.dat;

  assign iwbm_ack_o = own_i & wbm_ack_i;
  assign iwbm_err_o = own_i & (wbm_err_i | wd_fire);
  assign iwbm_rty_o = own_i & wbm_rty_i;
  assign dwbm_ack_o = own_d & wbm_ack_i;
  assign dwbm_err_o = own_d & (wbm_err_i | wd_fire);
  assign dwbm_rty_o = own_d & wbm_rty_i;

  // Read data is qualified by ack alone, so it is not gated here.
  assign iwbm_dat_o = wbm_dat_i;
  assign dwbm_dat_o = wbm_dat_i;

  assign grant_o = {own_d, own_i};

endmodule
